ipf_lcu_sched: RTL and testbench
================================

Name: ipf_lcu_sched

Overview:
- Feeds the image-processing filter: walks the 128x128 image in 64 LCUs of 16x16, raster order (lcu_x fastest).
- For each LCU, fetches the 24-bit filter parameter word from a parameter memory and streams 256 pixels from the image memory into the filter.
- Obeys the filter's busy/finish handshake.
- Sits between the image/parameter memories and the filter; presents the filter's input port set unchanged.

Parameters:
- PIX_BUF_DEPTH, 2, pixel skid-buffer entries (fixed at 2; covers 1-cycle memory latency at 1 pixel/cycle).
- LCU_SIZE_CODE, 2'd0, constant driven on lcu_size (0 = 16x16).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a frame when in IDLE
- done  out  1  high from filter finish until next accepted start
- param_rd  out  1  parameter memory read strobe
- param_addr  out  6  LCU index {lcu_y,lcu_x}
- param_data  in  24  {ipf_type[1:0], band_pos[4:0], wo_class, offset[15:0]}; valid the cycle after param_rd
- img_rd  out  1  image memory read strobe
- img_addr  out  14  {lcu_y, row[3:0], lcu_x, col[3:0]}
- img_data  in  8  valid the cycle after img_rd
- flt_busy  in  1  filter busy; a pixel is consumed on an edge where in_en=1 and flt_busy=0
- flt_finish  in  1  filter finish
- in_en  out  1  din valid
- din  out  8  pixel to filter
- ipf_type  out  2  from parameter word
- ipf_band_pos  out  5  from parameter word
- ipf_wo_class  out  1  from parameter word
- ipf_offset  out  16  from parameter word
- lcu_x  out  3  current LCU column
- lcu_y  out  3  current LCU row
- lcu_size  out  2  = LCU_SIZE_CODE

Behaviour:
- Reset (any time, including mid-frame): all outputs 0, lcu_size = LCU_SIZE_CODE, state IDLE, buffer flushed, counters 0, shadow-valid cleared.
- States: IDLE, P_RD, P_LAT, STREAM, NEXT, FLUSH, DONE.
- IDLE: on start, go to P_RD with lcu index 0. start in any other state is ignored.
- P_RD: param_rd=1, param_addr=index; next state P_LAT.
- P_LAT: capture param_data straight into the live output registers (first LCU only); go to STREAM.
- STREAM, pixel issue:
  - img_rd=1 when issue_cnt<256 and (buffer occupancy + in-flight reads) < 2.
  - img_addr comes from issue_cnt: row=issue_cnt[7:4], col=issue_cnt[3:0].
  - Returned data is written into the 2-entry FIFO the cycle after img_rd.
- STREAM, pixel delivery:
  - in_en = FIFO non-empty; din = FIFO head.
  - Accept = in_en & !flt_busy; accept pops the FIFO and increments acc_cnt.
  - While flt_busy=1, din and in_en hold.
  - Sustained rate with flt_busy=0: 1 pixel/cycle after a 2-cycle initial latency from entering STREAM.
- Next-LCU parameter prefetch:
  - In STREAM, when index<63 and the shadow is empty, issue one param_rd for index+1 on a cycle with no conflict (param port is independent of the image port).
  - Latch the returned word into a shadow register; set shadow-valid.
- LCU boundary (accept of pixel 255):
  - On that same edge, copy the shadow into ipf_type/band_pos/wo_class/offset, increment {lcu_y,lcu_x} (x wraps 7->0 with y+1), clear counters and shadow-valid.
  - The filter samples new parameters while it waits between LCUs, so they must be live by then.
  - If the shadow is not yet valid at that edge, enter NEXT: hold outputs, in_en=0, until the word returns, then load it and resume STREAM.
  - No pixel of LCU n+1 is issued before pixel 255 of LCU n is accepted.
- Last LCU: after accept of pixel 255 with index=63, go to FLUSH.
  - in_en=0; lcu_x/lcu_y hold at 7/7 and parameters hold, so the filter can drain its trailing outputs.
- FLUSH -> DONE on flt_finish=1. DONE: done=1, outputs hold; start clears done and re-enters P_RD with index 0.
- flt_finish seen in any state other than FLUSH is ignored.
- Counters issue_cnt and acc_cnt are 9-bit (0..256); the FIFO never overflows because issue is gated by occupancy plus in-flight reads.

Test Plan:
- Reset then start, flt_busy=0, memory img[a]=a[7:0] -> din sequence 0,1,...,15,128,... for LCU0.
  - First in_en 3 cycles after start-to-P_LAT.
  - Exactly 256 accepts per LCU; 16384 total.
- flt_busy toggled 1 for 5 cycles mid-row at pixel 37 -> in_en stays 1, din holds img[(2<<7)+5] unchanged, no pixel lost or duplicated, occupancy never exceeds 2.
- param[1]=0x2A5F3C, param[0]=0x000000 -> ipf_type/offset switch to 0x2A5F3C decode on the exact edge pixel 255 of LCU0 is accepted; lcu_x goes 0->1 on the same edge.
- Parameter memory delayed (param_data returned late, shadow invalid at boundary) -> NEXT entered, in_en=0 until the word loads, then streaming resumes with correct params.
- Frame end: after pixel 255 of LCU63, in_en=0 and lcu_x=lcu_y=7 hold; flt_finish pulse -> done=1 next cycle; new start -> done=0, param_addr=0.
- reset asserted low during LCU 20 streaming -> all outputs 0 immediately; a subsequent start restarts at LCU0, pixel 0.

Source files
------------

// File: rtl/ipf_lcu_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : ipf_lcu_sched_if
// Purpose  : Bundle of the scheduler's memory-side and filter-side signals.
// Revision : 1.0 - initial release
// ============================================================================
interface ipf_lcu_sched_if;
    logic        start;
    logic        done;
    logic        param_rd;
    logic [5:0]  param_addr;
    logic [23:0] param_data;
    logic        img_rd;
    logic [13:0] img_addr;
    logic [7:0]  img_data;
    logic        flt_busy;
    logic        flt_finish;
    logic        in_en;
    logic [7:0]  din;
    logic [1:0]  ipf_type;
    logic [4:0]  ipf_band_pos;
    logic        ipf_wo_class;
    logic [15:0] ipf_offset;
    logic [2:0]  lcu_x;
    logic [2:0]  lcu_y;
    logic [1:0]  lcu_size;

    modport master (
        input  start, param_data, img_data, flt_busy, flt_finish,
        output done, param_rd, param_addr, img_rd, img_addr, in_en, din,
               ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset,
               lcu_x, lcu_y, lcu_size
    );

    modport slave (
        output start, param_data, img_data, flt_busy, flt_finish,
        input  done, param_rd, param_addr, img_rd, img_addr, in_en, din,
               ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset,
               lcu_x, lcu_y, lcu_size
    );
endinterface
`default_nettype wire

// File: rtl/ipf_lcu_sched.sv
`default_nettype none
// ============================================================================
// Module   : ipf_lcu_sched
// Purpose  : Walks a 128x128 frame in 16x16 LCUs, fetching each LCU's filter
//            parameters and streaming its pixels into the filter.
// Revision : 1.0 - initial release
// ============================================================================
module ipf_lcu_sched #(
    parameter int unsigned PIX_BUF_DEPTH = 2,
    parameter logic [1:0]  LCU_SIZE_CODE = 2'd0
) (
    input logic             clk,
    input logic             reset,
    ipf_lcu_sched_if.master bus
);
    localparam logic [2:0] c_DEPTH = 3'(PIX_BUF_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_P_RD   = 3'd1,
        S_P_LAT  = 3'd2,
        S_STREAM = 3'd3,
        S_NEXT   = 3'd4,
        S_FLUSH  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t      r_state;
    logic [5:0]  r_idx;
    logic [8:0]  r_issue_cnt;
    logic [8:0]  r_acc_cnt;
    logic        r_param_rd;
    logic [5:0]  r_param_addr;
    logic        r_prd_d;
    logic        r_pf_pend;
    logic [23:0] r_shadow;
    logic        r_shadow_vld;
    logic [23:0] r_param;
    logic        r_done;

    logic [7:0]  r_fifo [2];
    logic        r_wptr;
    logic        r_rptr;
    logic [1:0]  r_occ;
    logic        r_img_rd_d;

    logic        w_in_en;
    logic        w_acc;
    logic        w_last;
    logic        w_img_rd;
    logic        w_pf;

    assign w_in_en  = (r_state == S_STREAM) && (r_occ != 2'd0);
    assign w_acc    = w_in_en && !bus.flt_busy;
    assign w_last   = w_acc && (r_acc_cnt == 9'd255);
    // Occupancy after this edge (write-back minus pop) must leave room for one more read.
    assign w_img_rd = (r_state == S_STREAM) && (r_issue_cnt < 9'd256) &&
                      (({1'b0, r_occ} + {2'b0, r_img_rd_d} - {2'b0, w_acc}) < c_DEPTH);
    assign w_pf     = (r_state == S_STREAM) && (r_idx != 6'd63) && !r_shadow_vld &&
                      !r_pf_pend && !r_param_rd;

    assign bus.done         = r_done;
    assign bus.param_rd     = r_param_rd;
    assign bus.param_addr   = r_param_addr;
    assign bus.img_rd       = w_img_rd;
    assign bus.img_addr     = {r_idx[5:3], r_issue_cnt[7:4], r_idx[2:0], r_issue_cnt[3:0]};
    assign bus.in_en        = w_in_en;
    assign bus.din          = r_fifo[r_rptr];
    assign bus.ipf_type     = r_param[23:22];
    assign bus.ipf_band_pos = r_param[21:17];
    assign bus.ipf_wo_class = r_param[16];
    assign bus.ipf_offset   = r_param[15:0];
    assign bus.lcu_x        = r_idx[2:0];
    assign bus.lcu_y        = r_idx[5:3];
    assign bus.lcu_size     = LCU_SIZE_CODE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fifo[0]  <= 8'd0;
            r_fifo[1]  <= 8'd0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_occ      <= 2'd0;
            r_img_rd_d <= 1'b0;
        end else begin
            r_img_rd_d <= w_img_rd;
            if (r_img_rd_d) begin
                r_fifo[r_wptr] <= bus.img_data;
                r_wptr         <= ~r_wptr;
            end
            if (w_acc) begin
                r_rptr <= ~r_rptr;
            end
            r_occ <= r_occ + {1'b0, r_img_rd_d} - {1'b0, w_acc};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_idx        <= 6'd0;
            r_issue_cnt  <= 9'd0;
            r_acc_cnt    <= 9'd0;
            r_param_rd   <= 1'b0;
            r_param_addr <= 6'd0;
            r_prd_d      <= 1'b0;
            r_pf_pend    <= 1'b0;
            r_shadow     <= 24'd0;
            r_shadow_vld <= 1'b0;
            r_param      <= 24'd0;
            r_done       <= 1'b0;
        end else begin
            r_param_rd <= 1'b0;
            r_prd_d    <= r_param_rd;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_state      <= S_P_RD;
                        r_idx        <= 6'd0;
                        r_done       <= 1'b0;
                        r_param_rd   <= 1'b1;
                        r_param_addr <= 6'd0;
                    end
                end
                S_P_RD: r_state <= S_P_LAT;
                S_P_LAT: begin
                    r_param <= bus.param_data;
                    r_state <= S_STREAM;
                end
                S_STREAM: begin
                    if (w_img_rd) r_issue_cnt <= r_issue_cnt + 9'd1;
                    if (w_acc)    r_acc_cnt   <= r_acc_cnt + 9'd1;
                    if (w_pf) begin
                        r_param_rd   <= 1'b1;
                        r_param_addr <= r_idx + 6'd1;
                        r_pf_pend    <= 1'b1;
                    end
                    if (r_prd_d && !w_last) begin
                        r_shadow     <= bus.param_data;
                        r_shadow_vld <= 1'b1;
                        r_pf_pend    <= 1'b0;
                    end
                    if (w_last) begin
                        r_issue_cnt  <= 9'd0;
                        r_acc_cnt    <= 9'd0;
                        r_shadow_vld <= 1'b0;
                        if (r_idx == 6'd63) begin
                            r_state <= S_FLUSH;
                        end else begin
                            r_idx <= r_idx + 6'd1;
                            // Word landing on the boundary edge itself bypasses the shadow.
                            if (r_shadow_vld) begin
                                r_param <= r_shadow;
                            end else if (r_prd_d) begin
                                r_param   <= bus.param_data;
                                r_pf_pend <= 1'b0;
                            end else begin
                                r_state <= S_NEXT;
                            end
                        end
                    end
                end
                S_NEXT: begin
                    if (r_prd_d) begin
                        r_param   <= bus.param_data;
                        r_pf_pend <= 1'b0;
                        r_state   <= S_STREAM;
                    end
                end
                S_FLUSH: begin
                    if (bus.flt_finish) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ipf_lcu_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ipf_lcu_sched
// Purpose  : Scoreboard bench for ipf_lcu_sched with behavioural memories.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ipf_lcu_sched;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ipf_lcu_sched_if bus ();

    ipf_lcu_sched #(.PIX_BUF_DEPTH(2), .LCU_SIZE_CODE(2'd0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    typedef struct packed {
        logic [5:0] lcu;
        logic [7:0] pix;
    } exp_t;

    exp_t        q[$];
    logic [23:0] pmem [64];
    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_fail = 0;

    initial begin
        for (int i = 0; i < 64; i++) pmem[i] = 24'h13579B ^ 24'(i * 24'h0A0B0C);
        pmem[0] = 24'h000000;
        pmem[1] = 24'h2A5F3C;
    end

    // One-cycle-latency memories; garbage on idle cycles exposes mistimed captures.
    always @(posedge clk) begin
        bus.param_data <= bus.param_rd ? pmem[bus.param_addr] : 24'hBAD0BA;
        bus.img_data   <= bus.img_rd   ? bus.img_addr[7:0]    : 8'hEE;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_pix(input int lcu, input int k);
        int x, y, row, col, a;
        x = lcu % 8;  y = lcu / 8;
        row = k / 16; col = k % 16;
        a = (y * 16 + row) * 128 + x * 16 + col;
        return 8'(a);
    endfunction

    function automatic logic [23:0] live_param();
        return {bus.ipf_type, bus.ipf_band_pos, bus.ipf_wo_class, bus.ipf_offset};
    endfunction

    // ---------------- monitor ----------------
    int         acc_total;
    int         issued;
    logic       prev_in_en, prev_busy, bnd_pend;
    logic [7:0] prev_din;
    logic [5:0] bnd_lcu;
    exp_t       e;

    always @(negedge clk) begin
        if (!reset) begin
            acc_total = 0; issued = 0;
            prev_in_en = 0; prev_busy = 0; bnd_pend = 0;
        end else begin
            if (bnd_pend) begin
                check("bnd_lcu_index", {bus.lcu_y, bus.lcu_x}, bnd_lcu);
                check("bnd_params", live_param(), pmem[bnd_lcu]);
                if (bnd_lcu == 6'd1) begin
                    check("bnd01_type",   bus.ipf_type,     2'd0);
                    check("bnd01_band",   bus.ipf_band_pos, 5'd21);
                    check("bnd01_wo",     bus.ipf_wo_class, 1'b0);
                    check("bnd01_offset", bus.ipf_offset,   16'h5F3C);
                end
                bnd_pend = 0;
            end
            if (prev_in_en && prev_busy)
                check("busy_hold", {bus.in_en, bus.din}, {1'b1, prev_din});
            if (bus.in_en && !bus.flt_busy) begin
                if (q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_pixel: got %0h expected none", bus.din);
                end else begin
                    e = q.pop_front();
                    check("din", bus.din, e.pix);
                    check("lcu_index", {bus.lcu_y, bus.lcu_x}, e.lcu);
                    check("params", live_param(), pmem[e.lcu]);
                    acc_total++;
                    if ((acc_total % 256) == 0 && e.lcu != 6'd63) begin
                        bnd_pend = 1;
                        bnd_lcu  = e.lcu + 6'd1;
                    end
                end
            end
            if (bus.img_rd) begin
                issued++;
                check("occupancy_le_2", (issued - acc_total) <= 2, 1'b1);
            end
            prev_in_en = bus.in_en;
            prev_busy  = bus.flt_busy;
            prev_din   = bus.din;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push_frame();
        for (int l = 0; l < 64; l++)
            for (int k = 0; k < 256; k++)
                q.push_back('{lcu: 6'(l), pix: exp_pix(l, k)});
    endtask

    task automatic start_frame();
        int lat;
        push_frame();
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        check("start_done_clr",   bus.done, 1'b0);
        check("start_param_rd",   bus.param_rd, 1'b1);
        check("start_param_addr", bus.param_addr, 6'd0);
        lat = 1;
        while (!bus.in_en && lat < 20) begin tick(); lat++; end
        check("first_in_en_latency", lat, 5);
    endtask

    task automatic wait_lcu(input int idx);
        int b;
        b = 0;
        while ({bus.lcu_y, bus.lcu_x} != 6'(idx) && b < 30000) begin tick(); b++; end
        check("wait_lcu_timeout", b < 30000, 1'b1);
    endtask

    task automatic wait_drain();
        int b;
        b = 0;
        while (q.size() != 0 && b < 30000) begin tick(); b++; end
        check("drain_timeout", b < 30000, 1'b1);
    endtask

    task automatic finish_frame();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("flush_in_en", bus.in_en, 1'b0);
            check("flush_lcu",   {bus.lcu_y, bus.lcu_x}, 6'd63);
            check("flush_param", live_param(), pmem[63]);
            check("flush_done",  bus.done, 1'b0);
        end
        bus.flt_finish = 1'b1; tick(); bus.flt_finish = 1'b0;
        check("done_set", bus.done, 1'b1);
        tick();
        check("done_hold", bus.done, 1'b1);
    endtask

    initial begin
        int b;
        bus.start = 1'b0; bus.flt_busy = 1'b0; bus.flt_finish = 1'b0;
        reset = 1'b1; #2; reset = 1'b0;
        repeat (3) tick();
        check("rst_outputs",
              {bus.done, bus.param_rd, bus.param_addr, bus.img_rd, bus.img_addr, bus.in_en, bus.din,
               live_param(), bus.lcu_x, bus.lcu_y}, 64'd0);
        check("rst_lcu_size", bus.lcu_size, 2'd0);
        reset = 1'b1;
        bus.flt_finish = 1'b1; tick(); bus.flt_finish = 1'b0;
        tick();
        check("idle_finish_ignored", bus.done, 1'b0);

        // Frame 1: busy stall at pixel 37, ignored start/finish, bursty busy in LCU 5
        start_frame();
        b = 0;
        while (acc_total < 37 && b < 1000) begin tick(); b++; end
        check("px37_timeout", b < 1000, 1'b1);
        bus.flt_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_en", bus.in_en, 1'b1);
            check("stall_din", bus.din, 8'd5);
            tick();
        end
        bus.flt_busy = 1'b0;
        wait_lcu(2);
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        wait_lcu(3);
        bus.flt_finish = 1'b1; tick(); bus.flt_finish = 1'b0;
        wait_lcu(5);
        b = 0;
        while ({bus.lcu_y, bus.lcu_x} == 6'd5 && b < 3000) begin
            bus.flt_busy = ((b % 4) == 1) || ((b % 7) == 3);
            tick(); b++;
        end
        bus.flt_busy = 1'b0;
        wait_drain();
        check("frame1_accepts", acc_total, 16384);
        finish_frame();

        // Frame 2: restart from DONE, then reset mid LCU 20
        start_frame();
        wait_lcu(20);
        repeat (40) tick();
        reset = 1'b0; #1;
        check("midrst_outputs",
              {bus.done, bus.param_rd, bus.param_addr, bus.img_rd, bus.img_addr, bus.in_en, bus.din,
               live_param(), bus.lcu_x, bus.lcu_y}, 64'd0);
        q.delete();
        tick(); tick();
        reset = 1'b1;
        tick();

        // Frame 3: full frame after reset restarts at LCU0 pixel 0
        start_frame();
        wait_drain();
        check("frame3_accepts", acc_total, 16384);
        finish_frame();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
`default_nettype wire
